// File: rtl/alarm_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_bank_if : time, set/control and status bundle for alarm_bank
// Revision 1.0
// ---------------------------------------------------------------------------
interface alarm_bank_if #(
  parameter int N_ALARMS = 4,
  parameter int SELW     = 2
);
  logic                sec_tick;
  logic [3:0]          now_min1;
  logic [3:0]          now_min2;
  logic [3:0]          now_hour1;
  logic [3:0]          now_hour2;
  logic                now_sec_zero;
  logic [SELW-1:0]     sel;
  logic                set_min;
  logic                set_hour;
  logic                en_toggle;
  logic [3:0]          digit1;
  logic [3:0]          digit2;
  logic                stop;
  logic                snooze;
  logic [3:0]          rd_min1;
  logic [3:0]          rd_min2;
  logic [3:0]          rd_hour1;
  logic [3:0]          rd_hour2;
  logic [N_ALARMS-1:0] alarm_en;
  logic                ringing;
  logic                snoozing;
  logic [SELW-1:0]     ring_id;
  logic                set_err;

  modport master (
    output sec_tick, now_min1, now_min2, now_hour1, now_hour2, now_sec_zero,
    output sel, set_min, set_hour, en_toggle, digit1, digit2, stop, snooze,
    input  rd_min1, rd_min2, rd_hour1, rd_hour2, alarm_en, ringing, snoozing,
    input  ring_id, set_err
  );

  modport slave (
    input  sec_tick, now_min1, now_min2, now_hour1, now_hour2, now_sec_zero,
    input  sel, set_min, set_hour, en_toggle, digit1, digit2, stop, snooze,
    output rd_min1, rd_min2, rd_hour1, rd_hour2, alarm_en, ringing, snoozing,
    output ring_id, set_err
  );
endinterface
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alarm_bank : N settable BCD HH:MM alarms with enable, match and ring/snooze
// Revision 1.0
// ---------------------------------------------------------------------------
module alarm_bank #(
  parameter int N_ALARMS    = 4,
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 300,
  parameter int SELW        = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam logic [7:0] RING_LIM = 8'(RING_SECS);
  localparam logic [9:0] SNZ_LIM  = 10'(SNOOZE_SECS);

  logic [N_ALARMS-1:0][3:0] min1_q, min1_d, min2_q, min2_d;
  logic [N_ALARMS-1:0][3:0] hour1_q, hour1_d, hour2_q, hour2_d;
  logic [N_ALARMS-1:0]      en_q, en_d;
  logic                     set_err_q, set_err_d;

  state_t                   state_q, state_d;
  logic [7:0]               ring_cnt_q, ring_cnt_d;
  logic [9:0]               snz_cnt_q, snz_cnt_d;
  logic [SELW-1:0]          ring_id_q, ring_id_d;
  logic                     ringing_q, ringing_d;
  logic                     snoozing_q, snoozing_d;

  logic                     sel_ok;
  logic                     hour_ok;
  logic                     min_ok;
  logic [N_ALARMS-1:0]      hit;
  logic                     any_hit;
  logic [SELW-1:0]          hit_id;
  logic [3:0]               rd_min1, rd_min2, rd_hour1, rd_hour2;

  assign sel_ok  = (32'(bus.sel) < N_ALARMS);
  assign hour_ok = (bus.digit1 <= 4'd9) &&
                   ((bus.digit2 < 4'd2) || ((bus.digit2 == 4'd2) && (bus.digit1 <= 4'd3)));
  assign min_ok  = (bus.digit1 <= 4'd9) && (bus.digit2 <= 4'd5);

  // A simultaneous hour+minute write is treated as an hour-only write.
  always_comb begin
    min1_d    = min1_q;
    min2_d    = min2_q;
    hour1_d   = hour1_q;
    hour2_d   = hour2_q;
    en_d      = en_q;
    set_err_d = 1'b0;
    if (bus.set_hour) begin
      if (!sel_ok || !hour_ok) begin
        set_err_d = 1'b1;
      end else begin
        for (int i = 0; i < N_ALARMS; i++) begin
          if (SELW'(i) == bus.sel) begin
            hour1_d[i] = bus.digit1;
            hour2_d[i] = bus.digit2;
          end
        end
      end
    end else if (bus.set_min) begin
      if (!sel_ok || !min_ok) begin
        set_err_d = 1'b1;
      end else begin
        for (int i = 0; i < N_ALARMS; i++) begin
          if (SELW'(i) == bus.sel) begin
            min1_d[i] = bus.digit1;
            min2_d[i] = bus.digit2;
          end
        end
      end
    end
    if (bus.en_toggle && sel_ok) begin
      for (int i = 0; i < N_ALARMS; i++) begin
        if (SELW'(i) == bus.sel) begin
          en_d[i] = ~en_q[i];
        end
      end
    end
  end

  always_comb begin
    rd_min1  = 4'd0;
    rd_min2  = 4'd0;
    rd_hour1 = 4'd0;
    rd_hour2 = 4'd0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (sel_ok && (SELW'(i) == bus.sel)) begin
        rd_min1  = min1_q[i];
        rd_min2  = min2_q[i];
        rd_hour1 = hour1_q[i];
        rd_hour2 = hour2_q[i];
      end
    end
  end

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_match
    assign hit[g] = en_q[g] &&
                    (min1_q[g]  == bus.now_min1)  && (min2_q[g]  == bus.now_min2) &&
                    (hour1_q[g] == bus.now_hour1) && (hour2_q[g] == bus.now_hour2);
  end

  // Only the seconds==00 tick qualifies, so each channel can fire once per minute.
  assign any_hit = bus.sec_tick && bus.now_sec_zero && (|hit);

  always_comb begin
    hit_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_id = SELW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    ring_id_d  = ring_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_hit) begin
          state_d    = ST_RING;
          ring_id_d  = hit_id;
          ring_cnt_d = 8'd0;
        end
      end
      ST_RING: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.snooze) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = 10'd0;
        end else if (bus.sec_tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_d == RING_LIM) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SNOOZE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.sec_tick) begin
          snz_cnt_d = snz_cnt_q + 10'd1;
          if (snz_cnt_d == SNZ_LIM) begin
            state_d    = ST_RING;
            ring_cnt_d = 8'd0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min1_q     <= '0;
      min2_q     <= '0;
      hour1_q    <= '0;
      hour2_q    <= '0;
      en_q       <= '0;
      set_err_q  <= 1'b0;
      state_q    <= ST_IDLE;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 10'd0;
      ring_id_q  <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      hour1_q    <= hour1_d;
      hour2_q    <= hour2_d;
      en_q       <= en_d;
      set_err_q  <= set_err_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      ring_id_q  <= ring_id_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign bus.rd_min1  = rd_min1;
  assign bus.rd_min2  = rd_min2;
  assign bus.rd_hour1 = rd_hour1;
  assign bus.rd_hour2 = rd_hour2;
  assign bus.alarm_en = en_q;
  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.ring_id  = ring_id_q;
  assign bus.set_err  = set_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alarm_bank : directed + random stimulus against a minutes-of-day model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_alarm_bank;
  localparam int N    = 4;
  localparam int SELW = 2;
  localparam int RS   = 30;
  localparam int SS   = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_bank_if #(.N_ALARMS(N), .SELW(SELW)) bus ();

  alarm_bank #(
    .N_ALARMS(N), .RING_SECS(RS), .SNOOZE_SECS(SS), .SELW(SELW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0]     rd;
    logic [N-1:0]    en;
    logic            ring;
    logic            snz;
    logic [SELW-1:0] id;
    logic            err;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Reference model: alarm times as minutes-of-day, mode 0/1/2 = idle/ring/snooze,
  // 'left' counts down the seconds remaining in the current ring or snooze.
  int now_s;
  int m_time [N];
  bit m_en   [N];
  int m_mode, m_left, m_id;
  bit m_err;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      cur = q.pop_front();
      check("readback", {bus.rd_hour2, bus.rd_hour1, bus.rd_min2, bus.rd_min1}, cur.rd);
      check("alarm_en", 16'(bus.alarm_en), 16'(cur.en));
      check("ringing",  16'(bus.ringing),  16'(cur.ring));
      check("snoozing", 16'(bus.snoozing), 16'(cur.snz));
      check("ring_id",  16'(bus.ring_id),  16'(cur.id));
      check("set_err",  16'(bus.set_err),  16'(cur.err));
    end
  end

  task automatic step(input bit rstn, input bit tick, input bit stp, input bit snz,
                      input bit sh, input bit sm, input bit tog,
                      input int s, input int d1, input int d2);
    int   hit;
    int   hr, mn, v;
    exp_t e;
    @(negedge clk);
    hr = now_s / 3600;
    mn = (now_s / 60) % 60;
    rst_n            = rstn;
    bus.sec_tick     = tick;
    bus.now_sec_zero = (now_s % 60 == 0);
    bus.now_hour1    = 4'(hr % 10);
    bus.now_hour2    = 4'(hr / 10);
    bus.now_min1     = 4'(mn % 10);
    bus.now_min2     = 4'(mn / 10);
    bus.sel          = SELW'(s);
    bus.set_hour     = sh;
    bus.set_min      = sm;
    bus.en_toggle    = tog;
    bus.digit1       = 4'(d1);
    bus.digit2       = 4'(d2);
    bus.stop         = stp;
    bus.snooze       = snz;

    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_time[i] = 0;
        m_en[i]   = 1'b0;
      end
      m_mode = 0; m_left = 0; m_id = 0; m_err = 1'b0;
    end else begin
      hit = -1;
      if (tick && (now_s % 60 == 0)) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (m_en[i] && m_time[i] == now_s / 60) hit = i;
        end
      end
      case (m_mode)
        0: if (hit >= 0) begin m_mode = 1; m_left = RS; m_id = hit; end
        1: begin
          if (stp) m_mode = 0;
          else if (snz) begin m_mode = 2; m_left = SS; end
          else if (tick) begin m_left--; if (m_left == 0) m_mode = 0; end
        end
        default: begin
          if (stp) m_mode = 0;
          else if (tick) begin
            m_left--;
            if (m_left == 0) begin m_mode = 1; m_left = RS; end
          end
        end
      endcase
      m_err = 1'b0;
      v = d2 * 10 + d1;
      if (sh) begin
        if (s < N && d1 <= 9 && v < 24) m_time[s] = v * 60 + m_time[s] % 60;
        else m_err = 1'b1;
      end else if (sm) begin
        if (s < N && d1 <= 9 && v < 60) m_time[s] = (m_time[s] / 60) * 60 + v;
        else m_err = 1'b1;
      end
      if (tog && s < N) m_en[s] = !m_en[s];
    end

    e.rd   = 16'd0;
    if (s < N) begin
      hr   = m_time[s] / 60;
      mn   = m_time[s] % 60;
      e.rd = {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10)};
    end
    for (int i = 0; i < N; i++) e.en[i] = m_en[i];
    e.ring = (m_mode == 1);
    e.snz  = (m_mode == 2);
    e.id   = SELW'(m_id);
    e.err  = m_err;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int s);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0, s, 0, 0);
  endtask

  task automatic sec(input int n);
    repeat (n) begin
      now_s = (now_s + 1) % 86400;
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic wr_hour(input int s, input int d1, input int d2);
    step(1, 0, 0, 0, 1, 0, 0, s, d1, d2);
    idle(1, s);
  endtask

  task automatic wr_min(input int s, input int d1, input int d2);
    step(1, 0, 0, 0, 0, 1, 0, s, d1, d2);
    idle(1, s);
  endtask

  task automatic tog(input int s);
    step(1, 0, 0, 0, 0, 0, 1, s, 0, 0);
  endtask

  int  r_s, r_d1, r_d2, r_w, r_mn;
  bit  r_tk, r_stp, r_snz, r_sh, r_sm, r_tg, r_rs;

  initial begin
    now_s = 7 * 3600;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 2);

    // Writes: valid hour, invalid hour, invalid minute, hour+minute together
    wr_hour(2, 1, 2);
    wr_hour(2, 2, 4);
    wr_min(2, 0, 6);
    step(1, 0, 0, 0, 1, 1, 0, 2, 7, 0);
    idle(1, 2);
    wr_hour(2, 10, 1);

    // Two channels at 07:30, lowest index wins; ring auto-stops after RS ticks
    wr_hour(1, 7, 0); wr_min(1, 0, 3); tog(1);
    wr_hour(3, 7, 0); wr_min(3, 0, 3); tog(3);
    now_s = 7 * 3600 + 29 * 60 + 58;
    sec(2);
    sec(RS + 5);

    // Snooze then re-ring after SS ticks, then stop+snooze together
    wr_hour(2, 7, 0); wr_min(2, 1, 3); tog(2);
    now_s = 7 * 3600 + 30 * 60 + 59;
    sec(1);
    sec(2);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    sec(SS + 5);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(3, 0);

    // Disabled channel ignored; enabled channel fires once per minute
    wr_hour(0, 8, 0); wr_min(0, 0, 0);
    now_s = 7 * 3600 + 59 * 60 + 59;
    sec(3);
    tog(0); wr_min(0, 5, 0);
    now_s = 8 * 3600 + 4 * 60 + 59;
    sec(11);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    sec(55);

    // Match during snooze is dropped; then reset mid-ring
    wr_hour(0, 6, 0); wr_min(0, 0, 0);
    wr_hour(1, 6, 0); wr_min(1, 1, 0);
    now_s = 5 * 3600 + 59 * 60 + 59;
    sec(4);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    sec(SS + 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 1);

    // Random phase
    now_s = 9 * 3600 + 10 * 60;
    for (int k = 0; k < 4000; k++) begin
      r_tk = ($urandom_range(0, 1) == 1);
      if (r_tk) begin
        if ($urandom_range(0, 9) == 0) now_s = (now_s / 60) * 60 + 59;
        now_s = (now_s + 1) % 86400;
      end
      r_stp = ($urandom_range(0, 49) == 0);
      r_snz = ($urandom_range(0, 29) == 0);
      r_w   = $urandom_range(0, 11);
      r_sh  = (r_w == 0) || (r_w == 2);
      r_sm  = (r_w == 1) || (r_w == 2);
      r_tg  = ($urandom_range(0, 19) == 0);
      r_rs  = ($urandom_range(0, 299) != 0);
      r_s   = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) begin
        r_d1 = $urandom_range(0, 15);
        r_d2 = $urandom_range(0, 15);
      end else if (r_sh) begin
        r_d1 = (now_s / 3600) % 10;
        r_d2 = (now_s / 3600) / 10;
      end else begin
        r_mn = ((now_s / 60) % 60 + 1) % 60;
        r_d1 = r_mn % 10;
        r_d2 = r_mn / 10;
      end
      step(r_rs, r_tk, r_stp, r_snz, r_sh, r_sm, r_tg, r_s, r_d1, r_d2);
    end

    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
